// File: rtl/controle_rega_pkg.sv
// Shared types for the irrigation controller: FSM states, level codes and the
// tank-sensor encoder.
package controle_rega_pkg;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        REGA    = 2'd1,
        LIMPEZA = 2'd2,
        MISTURA = 2'd3
    } estado_t;

    localparam logic [1:0] NV_CHEIO = 2'b11;
    localparam logic [1:0] NV_MEDIO = 2'b10;
    localparam logic [1:0] NV_BAIXO = 2'b01;
    localparam logic [1:0] NV_VAZIO = 2'b00;

    typedef struct packed {
        logic [1:0] nv;
        logic       invalido;
    } nivel_t;

    // Sensors stack bottom-up, so a wet upper sensor over a dry lower one is a fault.
    function automatic nivel_t codifica_nivel(input logic [2:0] amb);
        nivel_t r;
        r.invalido = 1'b0;
        case (amb)
            3'b111:  r.nv = NV_CHEIO;
            3'b011:  r.nv = NV_MEDIO;
            3'b001:  r.nv = NV_BAIXO;
            3'b000:  r.nv = NV_VAZIO;
            default: begin
                r.nv       = NV_VAZIO;
                r.invalido = 1'b1;
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/controle_rega_detector_borda.sv
// Two-flop synchronizer for an asynchronous level input followed by a
// rising-edge detector that emits a single-Clk pulse.
module detector_borda (
    input  logic Clk,
    input  logic Reset_n,
    input  logic din,
    output logic pulso
);

    // sr[1:0] is the synchronizer, sr[2] holds the previous synchronized value.
    logic [2:0] sr;

    always_ff @(posedge Clk) begin
        if (!Reset_n) sr <= '0;
        else          sr <= {sr[1:0], din};
    end

    assign pulso = sr[1] & ~sr[2];

endmodule

// File: rtl/controle_rega.sv
// Irrigation control FSM: tank-level encoding, timed watering / cleaning / mixing
// phases and the registered values consumed by the 7-segment display stage.
module controle_rega
    import controle_rega_pkg::*;
#(
    parameter logic [3:0] TEMPO_REGA = 4'd15,
    parameter logic [3:0] TEMPO_LIMP = 4'd8,
    parameter logic [3:0] TEMPO_MIST = 4'd5
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       Tick,
    input  logic       Seco,
    input  logic       NivelAlto,
    input  logic       NivelMedio,
    input  logic       NivelBaixo,
    input  logic       Pedido,
    output logic [1:0] Nv,
    output logic [3:0] ContA,
    output logic [1:0] ContB,
    output logic       Limp,
    output logic       Mist,
    output logic       Valvula,
    output logic       Erro
);

    estado_t    estado;
    logic [2:0] sens_q;
    nivel_t     nivel;
    logic       req;
    logic       pendente;

    detector_borda u_pedido (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .din     (Pedido),
        .pulso   (req)
    );

    assign nivel = codifica_nivel(sens_q);

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            estado   <= OCIOSO;
            sens_q   <= '0;
            pendente <= 1'b0;
            Nv       <= NV_VAZIO;
            ContA    <= '0;
            ContB    <= '0;
            Limp     <= 1'b0;
            Mist     <= 1'b0;
            Valvula  <= 1'b0;
            Erro     <= 1'b0;
        end else begin
            sens_q <= {NivelAlto, NivelMedio, NivelBaixo};
            Nv     <= nivel.nv;
            if (nivel.invalido) Erro <= 1'b1;
            if (req) pendente <= 1'b1;

            case (estado)
                OCIOSO: begin
                    if ((Seco || pendente) && Nv != NV_VAZIO) begin
                        estado   <= REGA;
                        ContA    <= TEMPO_REGA;
                        Valvula  <= 1'b1;
                        pendente <= 1'b0;
                    end
                end
                REGA: begin
                    // Running dry aborts at once and outranks any Tick.
                    if (Nv == NV_VAZIO) begin
                        estado  <= OCIOSO;
                        ContA   <= '0;
                        Valvula <= 1'b0;
                    end else if (Tick) begin
                        if (ContA != 4'd0) begin
                            ContA <= ContA - 4'd1;
                        end else begin
                            ContB   <= ContB + 2'd1;
                            Valvula <= 1'b0;
                            if (ContB == 2'd3) begin
                                estado <= LIMPEZA;
                                ContA  <= TEMPO_LIMP;
                                Limp   <= 1'b1;
                            end else begin
                                estado <= OCIOSO;
                            end
                        end
                    end
                end
                LIMPEZA: begin
                    if (Tick) begin
                        if (ContA != 4'd0) begin
                            ContA <= ContA - 4'd1;
                        end else begin
                            estado <= MISTURA;
                            ContA  <= TEMPO_MIST;
                            Limp   <= 1'b0;
                            Mist   <= 1'b1;
                        end
                    end
                end
                MISTURA: begin
                    if (Tick) begin
                        if (ContA != 4'd0) begin
                            ContA <= ContA - 4'd1;
                        end else begin
                            estado <= OCIOSO;
                            Mist   <= 1'b0;
                        end
                    end
                end
                default: estado <= OCIOSO;
            endcase
        end
    end

endmodule

// File: tb/tb_controle_rega.sv
// Directed and randomized checks for controle_rega against phase/tick arithmetic.
module tb_controle_rega;

    logic       Clk = 1'b0;
    logic       Reset_n, Tick, Seco, NivelAlto, NivelMedio, NivelBaixo, Pedido;
    logic [1:0] Nv, ContB;
    logic [3:0] ContA;
    logic       Limp, Mist, Valvula, Erro;

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    controle_rega dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .Tick       (Tick),
        .Seco       (Seco),
        .NivelAlto  (NivelAlto),
        .NivelMedio (NivelMedio),
        .NivelBaixo (NivelBaixo),
        .Pedido     (Pedido),
        .Nv         (Nv),
        .ContA      (ContA),
        .ContB      (ContB),
        .Limp       (Limp),
        .Mist       (Mist),
        .Valvula    (Valvula),
        .Erro       (Erro)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One Clk with the given Tick; returns at the following negedge.
    task automatic cyc(input logic t);
        Tick = t;
        @(posedge Clk);
        @(negedge Clk);
        Tick = 1'b0;
    endtask

    task automatic sens(input logic [2:0] v);
        {NivelAlto, NivelMedio, NivelBaixo} = v;
    endtask

    initial begin
        int dur [4];
        int ph, k, nc, exp_a;
        logic s, t;
        dur = '{0, 15, 8, 5};

        // Reset with every input high.
        Reset_n = 1'b0; Seco = 1'b1; Pedido = 1'b1; Tick = 1'b1;
        sens(3'b111);
        cyc(1); cyc(1); cyc(1);
        chk("rst_nv",    32'(Nv),      0);
        chk("rst_conta", 32'(ContA),   0);
        chk("rst_contb", 32'(ContB),   0);
        chk("rst_limp",  32'(Limp),    0);
        chk("rst_mist",  32'(Mist),    0);
        chk("rst_valv",  32'(Valvula), 0);
        chk("rst_erro",  32'(Erro),    0);
        Reset_n = 1'b1; Seco = 1'b0; Pedido = 1'b0;
        cyc(0);
        chk("nv_lat1", 32'(Nv), 0);
        cyc(0);
        chk("nv_lat2", 32'(Nv), 3);
        chk("idle_valv", 32'(Valvula), 0);

        // One watering cycle.
        Seco = 1'b1; cyc(0); Seco = 1'b0;
        chk("rega_entry_valv", 32'(Valvula), 1);
        chk("rega_entry_conta", 32'(ContA), 15);
        for (int i = 1; i <= 15; i++) begin
            cyc(1);
            chk("rega_cd", 32'(ContA), 32'(15 - i));
            chk("rega_cd_valv", 32'(Valvula), 1);
        end
        cyc(1);
        chk("rega_end_contb", 32'(ContB), 1);
        chk("rega_end_valv", 32'(Valvula), 0);
        cyc(0);
        chk("rega_idle_valv", 32'(Valvula), 0);
        chk("rega_idle_conta", 32'(ContA), 0);

        // Three more cycles: ContB wraps and cleaning begins.
        for (int c = 2; c <= 4; c++) begin
            Seco = 1'b1; cyc(0); Seco = 1'b0;
            repeat (16) cyc(1);
            chk("wrap_contb", 32'(ContB), 32'(c % 4));
        end
        chk("limp_on", 32'(Limp), 1);
        chk("limp_conta", 32'(ContA), 8);
        chk("limp_valv", 32'(Valvula), 0);
        chk("limp_mist", 32'(Mist), 0);

        // Manual request during cleaning is held.
        Pedido = 1'b1; cyc(0); cyc(0); cyc(0); Pedido = 1'b0; cyc(0);
        chk("ped_hold_limp", 32'(Limp), 1);
        chk("ped_hold_valv", 32'(Valvula), 0);
        repeat (9) cyc(1);
        chk("mist_limp", 32'(Limp), 0);
        chk("mist_on", 32'(Mist), 1);
        chk("mist_conta", 32'(ContA), 5);
        repeat (5) cyc(1);
        chk("mist_last", 32'(Mist), 1);
        chk("mist_last_conta", 32'(ContA), 0);
        cyc(1);
        chk("mist_off", 32'(Mist), 0);
        chk("mist_off_valv", 32'(Valvula), 0);
        cyc(0);
        chk("ped_rega_valv", 32'(Valvula), 1);
        chk("ped_rega_conta", 32'(ContA), 15);

        // Abort with a Tick on every cycle, including the abort cycle.
        repeat (8) cyc(1);
        chk("abort_pre", 32'(ContA), 7);
        sens(3'b000);
        cyc(1); cyc(1); cyc(1);
        chk("abort_valv", 32'(Valvula), 0);
        chk("abort_conta", 32'(ContA), 0);
        chk("abort_contb", 32'(ContB), 0);
        chk("abort_nv", 32'(Nv), 0);
        chk("abort_erro", 32'(Erro), 0);
        Seco = 1'b1; cyc(0); cyc(0); cyc(0);
        chk("empty_no_rega", 32'(Valvula), 0);
        Seco = 1'b0;

        // Invalid combination sets the sticky error.
        sens(3'b100); cyc(0); cyc(0);
        chk("inv_nv", 32'(Nv), 0);
        chk("inv_erro", 32'(Erro), 1);
        sens(3'b111); cyc(0); cyc(0);
        chk("inv_rec_nv", 32'(Nv), 3);
        chk("inv_sticky", 32'(Erro), 1);
        Reset_n = 1'b0; cyc(0); Reset_n = 1'b1;
        chk("inv_rst_erro", 32'(Erro), 0);
        cyc(0); cyc(0);
        chk("rand_pre_nv", 32'(Nv), 3);

        // Randomized Seco/Tick against tick-counting phase model (tank full).
        ph = 0; k = 0; nc = 0;
        for (int i = 0; i < 600; i++) begin
            s = ($urandom_range(0, 3) == 0);
            t = ($urandom_range(0, 2) == 0);
            Seco = s;
            cyc(t);
            if (ph == 0) begin
                if (s) begin ph = 1; k = 0; end
            end else if (t) begin
                k++;
                if (k > dur[ph]) begin
                    k = 0;
                    if (ph == 1) begin
                        nc = (nc + 1) % 4;
                        ph = (nc == 0) ? 2 : 0;
                    end else if (ph == 2) ph = 3;
                    else ph = 0;
                end
            end
            exp_a = (ph == 0) ? 0 : dur[ph] - k;
            chk("r_conta", 32'(ContA), 32'(exp_a));
            chk("r_contb", 32'(ContB), 32'(nc));
            chk("r_valv",  32'(Valvula), 32'(ph == 1));
            chk("r_limp",  32'(Limp), 32'(ph == 2));
            chk("r_mist",  32'(Mist), 32'(ph == 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
